// File: rtl/mips_pkg.sv
// Types and constants shared by the instruction-fetch stage: FSM states,
// the reset PC, and where the immediate and jump-index fields sit in an instruction.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } if_state_e;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int JIDX_MSB  = 25;
  localparam int JIDX_LSB  = 0;
  localparam int JHI_MSB   = 31;
  localparam int JHI_LSB   = 28;

  // Branch displacement: sign-extended 16-bit word offset, turned into a byte offset.
  function automatic logic [31:0] branch_off(input logic [31:0] instr);
    return {{14{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection for the fetch stage. A jump wins over a taken branch.
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0] pcplus4,
  input  logic [31:0] instr,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] next_pc
);

  logic unused_opcode;
  assign unused_opcode = ^instr[31:JIDX_MSB+1];

  always_comb begin
    next_pc = pcplus4;
    if (jump)
      next_pc = {pcplus4[JHI_MSB:JHI_LSB], instr[JIDX_MSB:JIDX_LSB], 2'b00};
    else if (pcsrc)
      next_pc = pcplus4 + branch_off(instr);
  end

endmodule

// File: rtl/if_stage.sv
// Multi-cycle instruction fetch: request from imem, hold the word for one execute
// cycle, then advance the PC. Halting freezes everything until reset.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic [31:0] instret
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] next_pc;

  pc_next u_pc_next (
    .pcplus4 (pcplus4),
    .instr   (instr_q),
    .pcsrc   (pcsrc),
    .jump    (jump),
    .next_pc (next_pc)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    unique case (state_q)
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        pc_d      = next_pc;
        instret_d = instret_q + 32'd1;
        state_d   = halt ? HALTED : FETCH;
      end
      HALTED: ;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_ADDR;
      instr_q   <= 32'h0;
      instret_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
    end
  end

  // The request is gated by reset directly so it drops in the same cycle reset asserts.
  assign imem_req    = (state_q == FETCH) && reset;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == EXEC);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign pcplus4     = pc_q + 32'd4;
  assign instret     = instret_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: an instruction-level model predicts pc, instr and
// instret for every fetch/execute pair and is compared cycle by cycle.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        pcsrc;
  logic        jump;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic [31:0] instret;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic [31:0] exp_instret;

  if_stage dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pcsrc       (pcsrc),
    .jump        (jump),
    .halt        (halt),
    .pc          (pc),
    .pcplus4     (pcplus4),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // Architectural next-PC rule written as plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                           input logic ps, input logic jp);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(ins[15:0]));
    if (jp) return (seq & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
    if (ps) return seq + 32'(off * 4);
    return seq;
  endfunction

  task automatic chk_fetch(input string tag);
    chk({tag, ".req"},   32'(imem_req),    32'd1);
    chk({tag, ".addr"},  imem_addr,        exp_pc);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
  endtask

  // Enter with the DUT in FETCH at a falling edge; leaves at the falling edge after EXEC.
  task automatic run_instr(input int dly, input logic [31:0] data,
                           input logic ps, input logic jp, input logic hl);
    for (int i = 0; i < dly; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      pcsrc      = 1'($urandom);
      jump       = 1'($urandom);
      halt       = hl;
      #1 chk_fetch("wait");
      @(negedge clk);
    end
    imem_ready = 1'b1;
    imem_rdata = data;
    pcsrc      = 1'($urandom);
    jump       = 1'($urandom);
    halt       = hl;
    #1 chk_fetch("rdy");
    @(negedge clk);
    imem_ready = 1'($urandom);
    imem_rdata = $urandom;
    pcsrc      = ps;
    jump       = jp;
    halt       = hl;
    #1;
    chk("exec.valid",   32'(instr_valid), 32'd1);
    chk("exec.req",     32'(imem_req),    32'd0);
    chk("exec.instr",   instr,            data);
    chk("exec.pc",      pc,               exp_pc);
    chk("exec.pcplus4", pcplus4,          exp_pc + 32'd4);
    chk("exec.instret", instret,          exp_instret);
    @(negedge clk);
    exp_pc      = ref_next(exp_pc, data, ps, jp);
    exp_instr   = data;
    exp_instret = exp_instret + 32'd1;
    imem_ready  = 1'b0;
    pcsrc       = 1'b0;
    jump        = 1'b0;
    halt        = 1'b0;
  endtask

  // Reset with a stray imem_ready held high; leaves DUT released in FETCH.
  task automatic do_reset();
    reset      = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rst.req",     32'(imem_req),    32'd0);
    chk("rst.pc",      pc,               32'h0);
    chk("rst.instr",   instr,            32'h0);
    chk("rst.instret", instret,          32'h0);
    chk("rst.valid",   32'(instr_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    imem_ready  = 1'b0;
    reset       = 1'b1;
    exp_pc      = 32'h0;
    exp_instr   = 32'h0;
    exp_instret = 32'h0;
    #1 chk_fetch("post_rst");
    chk("post_rst.instr", instr, 32'h0);
  endtask

  initial begin
    reset = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
    pcsrc = 1'b0; jump = 1'b0; halt = 1'b0;
    @(negedge clk);
    do_reset();
    @(negedge clk);

    // Back-to-back fetches with memory always ready.
    for (int i = 0; i < 3; i++) run_instr(0, $urandom, 1'b0, 1'b0, 1'b0);
    chk("seq.instret", instret, 32'd3);
    chk("seq.pc",      pc,      32'hC);

    // Stalled memory.
    run_instr(5, $urandom, 1'b0, 1'b0, 1'b0);

    // Branch back to self, then forward by three words.
    do_reset();
    @(negedge clk);
    run_instr(0, 32'h0800_0040, 1'b0, 1'b1, 1'b0);
    #1 chk("jmp.pc", pc, 32'h100);
    run_instr(1, 32'h1000_FFFF, 1'b1, 1'b0, 1'b0);
    #1 chk("br_self.pc", pc, 32'h100);
    run_instr(0, 32'h1000_0003, 1'b1, 1'b0, 1'b0);
    #1 chk("br_fwd.pc", pc, 32'h110);

    // Wrap: branch from 0 to 0xFFFF_FFFC, then fall through to 0.
    do_reset();
    @(negedge clk);
    run_instr(0, 32'h1000_FFFE, 1'b1, 1'b0, 1'b0);
    #1 chk("wrap.pc_hi", pc, 32'hFFFF_FFFC);
    run_instr(0, $urandom, 1'b0, 1'b0, 1'b0);
    #1 chk("wrap.pc_lo", pc, 32'h0);

    // Jump has priority over branch, high nibble from pc+4.
    force dut.pc_q = 32'h3000_0000;
    #1 release dut.pc_q;
    exp_pc = 32'h3000_0000;
    @(negedge clk);
    run_instr(0, 32'h0000_0040, 1'b1, 1'b1, 1'b0);
    #1 chk("jprio.pc", pc, 32'h3000_0100);

    // Retired-count wrap.
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    exp_instret = 32'hFFFF_FFFF;
    @(negedge clk);
    run_instr(0, $urandom, 1'b0, 1'b0, 1'b0);
    #1 chk("instret.wrap", instret, 32'h0);

    // Random traffic.
    @(negedge clk);
    for (int i = 0; i < 40; i++)
      run_instr(int'($urandom_range(0, 3)), $urandom, 1'($urandom), 1'($urandom), 1'b0);

    // Reset in the middle of a stalled fetch.
    imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    do_reset();
    @(negedge clk);
    run_instr(1, $urandom, 1'b0, 1'b0, 1'b0);

    // Halt raised during fetch: the instruction still executes, then freeze.
    run_instr(2, $urandom, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'b1;
      imem_rdata = $urandom;
      #1;
      chk("halt.req",     32'(imem_req),    32'd0);
      chk("halt.valid",   32'(instr_valid), 32'd0);
      chk("halt.pc",      pc,               exp_pc);
      chk("halt.instr",   instr,            exp_instr);
      chk("halt.instret", instret,          exp_instret);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
